// File: rtl/hls_mem_harness.sv
// rtl/hls_mem_harness.sv - memory model, result checker and logic-analyzer log for an HLS core
//
// Serves the single memory port of an HLS-generated core: reads complete with a
// fixed latency, writes land in a modelled memory, and writes into the result
// window are compared against a preloaded expected table. Every write is logged
// through a small FIFO and shifted out LSB first on the la_* pins.
//
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   init_we/sel/idx/data       preload of memory (sel=0) or expected table (sel=1), only while !core_start
//   core_start                 core running
//   mem_oe/we/addr/wdata/size  core memory request
//   mem_rdata, mem_data_rdy    read data and one-cycle completion pulse
//   core_done                  core finished
//   pass, fail, err_code       sticky verdict and first error cause
//   la_clk, la_data, la_frame  serial write log
module hls_mem_harness #(
    parameter int                ADDR_W      = 64,
    parameter int                DATA_W      = 64,
    parameter logic [ADDR_W-1:0] MEM_BASE    = 64'h4000_0000,
    parameter int                MEM_WORDS   = 64,
    parameter int                NUM_RESULTS = 2,
    parameter logic [ADDR_W-1:0] RES_BASE    = 64'h4000_0100,
    parameter int                RD_LAT      = 1,
    parameter int                FIFO_DEPTH  = 4,
    parameter int                SER_DIV     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_we,
    input  logic              init_sel,
    input  logic [$clog2((MEM_WORDS > NUM_RESULTS) ? MEM_WORDS : NUM_RESULTS)-1:0] init_idx,
    input  logic [DATA_W-1:0] init_data,
    input  logic              core_start,
    input  logic              mem_oe,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [11:0]       mem_size,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_data_rdy,
    input  logic              core_done,
    output logic              pass,
    output logic              fail,
    output logic [2:0]        err_code,
    output logic              la_clk,
    output logic              la_data,
    output logic              la_frame
);

    localparam int BSH      = $clog2(DATA_W / 8);
    localparam int MW       = $clog2(MEM_WORDS);
    localparam int RW       = (NUM_RESULTS > 1) ? $clog2(NUM_RESULTS) : 1;
    localparam int FW       = $clog2(FIFO_DEPTH);
    localparam int DVW      = $clog2(SER_DIV);
    localparam int BTW      = $clog2(DATA_W);
    localparam int RES_IDX0 = int'((RES_BASE - MEM_BASE) >> BSH);

    typedef enum logic [1:0] {A_IDLE, A_BUSY, A_RESP} a_state_t;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} s_state_t;

    a_state_t a_state, a_next;
    s_state_t s_state, s_next;

    logic [DATA_W-1:0] mem     [MEM_WORDS];
    logic [DATA_W-1:0] exp_mem [NUM_RESULTS];
    logic [DATA_W-1:0] fifo_mem[FIFO_DEPTH];

    logic [ADDR_W-1:0] offset, idx_full;
    logic              in_win, in_res, res_match;
    logic [RW-1:0]     res_sel;
    logic              acc_req, wr_acc;
    logic [2:0]        err_now;

    logic [2:0]        lat_cnt;
    logic              acc_rd;
    logic [DATA_W-1:0] rd_word;

    logic [FW:0]       wr_ptr, rd_ptr;
    logic              fifo_empty, fifo_full, fifo_pop, log_push, log_drop;

    logic [DVW-1:0]    div_cnt;
    logic [BTW-1:0]    bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              div_last, bit_last;

    logic [NUM_RESULTS-1:0] matched;
    logic                   done_seen;

    // ---------------- address decode ----------------
    assign offset   = mem_addr - MEM_BASE;
    assign idx_full = offset >> BSH;
    assign in_win   = (mem_addr >= MEM_BASE)
                   && ((offset & ADDR_W'(DATA_W / 8 - 1)) == '0)
                   && (idx_full < ADDR_W'(MEM_WORDS));
    assign in_res   = in_win
                   && (idx_full >= ADDR_W'(RES_IDX0))
                   && (idx_full < ADDR_W'(RES_IDX0 + NUM_RESULTS));
    assign res_sel   = RW'(idx_full - ADDR_W'(RES_IDX0));
    assign res_match = (mem_wdata == exp_mem[res_sel]);

    // A request is only sampled in IDLE; oe&we together is handled as a write.
    assign acc_req = (a_state == A_IDLE) && (mem_oe || mem_we);
    assign wr_acc  = acc_req && mem_we;

    // Lowest code wins when several causes coincide.
    always_comb begin
        err_now = 3'd0;
        if (acc_req) begin
            if (wr_acc && in_res && !res_match)   err_now = 3'd1;
            else if (!in_win)                     err_now = 3'd2;
            else if (mem_size != 12'(DATA_W))     err_now = 3'd3;
            else if (mem_oe && mem_we)            err_now = 3'd4;
        end
        if (err_now == 3'd0 && log_drop)          err_now = 3'd5;
    end

    // ---------------- storage (not reset) ----------------
    always_ff @(posedge clk) begin
        if (wr_acc && in_win)
            mem[idx_full[MW-1:0]] <= mem_wdata;
        else if (init_we && !core_start && !init_sel && int'(init_idx) < MEM_WORDS)
            mem[init_idx[MW-1:0]] <= init_data;
    end

    always_ff @(posedge clk) begin
        if (init_we && !core_start && init_sel && int'(init_idx) < NUM_RESULTS)
            exp_mem[init_idx[RW-1:0]] <= init_data;
    end

    always_ff @(posedge clk) begin
        if (log_push)
            fifo_mem[wr_ptr[FW-1:0]] <= mem_wdata;
    end

    // ---------------- access FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) a_state <= A_IDLE;
        else        a_state <= a_next;
    end

    always_comb begin
        a_next = a_state;
        case (a_state)
            A_IDLE: if (acc_req) a_next = (RD_LAT == 1) ? A_RESP : A_BUSY;
            A_BUSY: if (lat_cnt == 3'd0) a_next = A_RESP;
            A_RESP: a_next = A_IDLE;
            default: a_next = A_IDLE;
        endcase
    end

    always_comb begin
        mem_data_rdy = (a_state == A_RESP);
        mem_rdata    = (a_state == A_RESP && acc_rd) ? rd_word : '0;
    end

    // BUSY holds RD_LAT-1 cycles so the RESP cycle falls RD_LAT cycles after the request edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_cnt <= 3'd0;
            acc_rd  <= 1'b0;
            rd_word <= '0;
        end else if (acc_req) begin
            lat_cnt <= 3'((RD_LAT > 1) ? RD_LAT - 2 : 0);
            acc_rd  <= !mem_we;
            rd_word <= (!mem_we && in_win) ? mem[idx_full[MW-1:0]] : '0;
        end else if (a_state == A_BUSY) begin
            lat_cnt <= lat_cnt - 3'd1;
        end
    end

    // ---------------- checker / verdict ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fail      <= 1'b0;
            err_code  <= 3'd0;
            pass      <= 1'b0;
            matched   <= '0;
            done_seen <= 1'b0;
        end else begin
            if (!fail && err_now != 3'd0) begin
                fail     <= 1'b1;
                err_code <= err_now;
            end
            if (wr_acc && in_res && res_match)
                matched[res_sel] <= 1'b1;
            if (core_done)
                done_seen <= 1'b1;
            if ((&matched) && (done_seen || core_done) && !fail && err_now == 3'd0)
                pass <= 1'b1;
        end
    end

    // ---------------- write-log FIFO ----------------
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[FW] != rd_ptr[FW]) && (wr_ptr[FW-1:0] == rd_ptr[FW-1:0]);
    assign fifo_pop   = (s_state == S_IDLE) && !fifo_empty;
    // A full FIFO still accepts a push when the serialiser pops in the same cycle.
    assign log_push   = wr_acc && (!fifo_full || fifo_pop);
    assign log_drop   = wr_acc && fifo_full && !fifo_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (log_push) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // ---------------- serialiser FSM ----------------
    assign div_last = (div_cnt == DVW'(SER_DIV - 1));
    assign bit_last = (bit_cnt == BTW'(DATA_W - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) s_state <= S_IDLE;
        else        s_state <= s_next;
    end

    always_comb begin
        s_next = s_state;
        case (s_state)
            S_IDLE:  if (!fifo_empty) s_next = S_SHIFT;
            S_SHIFT: if (div_last && bit_last) s_next = S_GAP;
            S_GAP:   if (div_last) s_next = S_IDLE;
            default: s_next = S_IDLE;
        endcase
    end

    // Each bit period starts with la_clk low, so la_data moves on the falling edge.
    always_comb begin
        la_frame = (s_state == S_SHIFT);
        la_clk   = (s_state == S_SHIFT) && (div_cnt >= DVW'(SER_DIV / 2));
        la_data  = (s_state == S_SHIFT) && shreg[0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            case (s_state)
                S_IDLE: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    if (fifo_pop) shreg <= fifo_mem[rd_ptr[FW-1:0]];
                end
                S_SHIFT: begin
                    div_cnt <= div_last ? '0 : div_cnt + 1'b1;
                    if (div_last) begin
                        shreg   <= shreg >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    div_cnt <= div_last ? '0 : div_cnt + 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hls_mem_harness.sv
// tb/tb_hls_mem_harness.sv - scoreboard bench for hls_mem_harness
module tb_hls_mem_harness;

    localparam int RD_LAT = 3;
    localparam logic [63:0] E0 = 64'h04b2008fd98c1dd4;
    localparam logic [63:0] E1 = 64'h7e42f8ec980980e9;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        init_we = 1'b0;
    logic        init_sel = 1'b0;
    logic [5:0]  init_idx = '0;
    logic [63:0] init_data = '0;
    logic        core_start = 1'b0;
    logic        mem_oe = 1'b0;
    logic        mem_we = 1'b0;
    logic [63:0] mem_addr = '0;
    logic [63:0] mem_wdata = '0;
    logic [11:0] mem_size = 12'd64;
    logic [63:0] mem_rdata;
    logic        mem_data_rdy;
    logic        core_done = 1'b0;
    logic        pass, fail;
    logic [2:0]  err_code;
    logic        la_clk, la_data, la_frame;

    hls_mem_harness #(.RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .init_we(init_we), .init_sel(init_sel), .init_idx(init_idx), .init_data(init_data),
        .core_start(core_start),
        .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_rdata(mem_rdata), .mem_data_rdy(mem_data_rdy),
        .core_done(core_done), .pass(pass), .fail(fail), .err_code(err_code),
        .la_clk(la_clk), .la_data(la_data), .la_frame(la_frame)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          issue;
        bit          chk;
        logic [63:0] rdata;
    } acc_t;

    acc_t        acc_q[$];
    logic [63:0] frame_q[$];
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Response monitor: pairs every completion pulse with the oldest issued access.
    initial begin : rsp_mon
        logic  prev_rdy;
        acc_t  e;
        prev_rdy = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_rdy = 1'b0;
            end else begin
                if (mem_data_rdy) begin
                    check("rdy_single_pulse", 64'(prev_rdy), 64'd0);
                    if (acc_q.size() == 0) begin
                        fail_now("unexpected_rdy");
                    end else begin
                        e = acc_q.pop_front();
                        check("rd_latency", 64'(cyc - e.issue), 64'(RD_LAT));
                        if (e.chk) check("rdata", mem_rdata, e.rdata);
                    end
                end else if (prev_rdy) begin
                    check("rdata_zero_after_resp", mem_rdata, 64'd0);
                end
                prev_rdy = mem_data_rdy;
            end
        end
    end

    // Frame monitor: samples la_data on each la_clk rise inside a frame.
    initial begin : frame_mon
        logic [63:0] fword;
        int          fbits;
        bit          fin;
        logic        prev_lclk;
        fword = '0; fbits = 0; fin = 1'b0; prev_lclk = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                fbits = 0; fin = 1'b0; prev_lclk = 1'b0;
            end else begin
                if (la_frame) begin
                    fin = 1'b1;
                    if (la_clk && !prev_lclk) begin
                        if (fbits < 64) fword[fbits] = la_data;
                        fbits++;
                    end
                end else if (fin) begin
                    check("frame_bits", 64'(fbits), 64'd64);
                    if (frame_q.size() == 0) fail_now("unexpected_frame");
                    else check("frame_word", fword, frame_q.pop_front());
                    fin = 1'b0;
                    fbits = 0;
                end
                prev_lclk = la_clk;
            end
        end
    end

    task automatic access(input bit oe, input bit we, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [11:0] size,
                          input bit chk, input logic [63:0] exp_rd);
        acc_t e;
        bit   got;
        @(posedge clk); #1;
        mem_oe = oe; mem_we = we; mem_addr = addr; mem_wdata = wdata; mem_size = size;
        e.issue = cyc; e.chk = chk; e.rdata = exp_rd;
        acc_q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_data_rdy) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            fail_now("rdy_timeout");
            acc_q.delete();
        end
        @(posedge clk); #1;
        mem_oe = 1'b0; mem_we = 1'b0; mem_size = 12'd64;
    endtask

    task automatic wr(input logic [63:0] addr, input logic [63:0] data, input bit logged);
        if (logged) frame_q.push_back(data);
        access(1'b0, 1'b1, addr, data, 12'd64, 1'b0, 64'd0);
    endtask

    task automatic rd(input logic [63:0] addr, input logic [63:0] exp);
        access(1'b1, 1'b0, addr, 64'd0, 12'd64, 1'b1, exp);
    endtask

    task automatic preload(input bit sel, input logic [5:0] idx, input logic [63:0] data);
        @(posedge clk); #1;
        init_we = 1'b1; init_sel = sel; init_idx = idx; init_data = data;
        @(posedge clk); #1;
        init_we = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("rst_la_frame", 64'(la_frame), 64'd0);
        check("rst_la_clk", 64'(la_clk), 64'd0);
        check("rst_la_data", 64'(la_data), 64'd0);
        check("rst_rdy", 64'(mem_data_rdy), 64'd0);
        check("rst_rdata", mem_rdata, 64'd0);
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_fail", 64'(fail), 64'd0);
        check("rst_err", 64'(err_code), 64'd0);
        frame_q.delete();
        acc_q.delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic wait_frame_start();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (la_frame) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail_now("frame_start_timeout");
    endtask

    task automatic wait_frames_drained(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (frame_q.size() == 0 && !la_frame) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) fail_now("frames_drain_timeout");
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog expired");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $finish;
    end

    initial begin : stim
        bit seen;

        // reset state and preload
        do_reset();
        preload(1'b0, 6'd0, 64'h80);
        preload(1'b1, 6'd0, E0);
        preload(1'b1, 6'd1, E1);
        core_start = 1'b1;

        // read latency and data, then a passing run
        rd(64'h4000_0000, 64'h80);
        wr(64'h4000_0100, E0, 1'b1);
        wr(64'h4000_0108, E1, 1'b1);
        check("pass_before_done", 64'(pass), 64'd0);
        @(posedge clk); #1 core_done = 1'b1;
        @(negedge clk);
        check("pass_same_cycle_as_done", 64'(pass), 64'd0);
        @(negedge clk);
        check("pass_after_done", 64'(pass), 64'd1);
        check("fail_on_pass", 64'(fail), 64'd0);
        check("err_on_pass", 64'(err_code), 64'd0);
        rd(64'h4000_0100, E0);
        wait_frames_drained(1500);
        core_done = 1'b0;

        // mismatch is sticky and blocks pass
        do_reset();
        wr(64'h4000_0100, 64'h1, 1'b1);
        check("mismatch_fail", 64'(fail), 64'd1);
        check("mismatch_err", 64'(err_code), 64'd1);
        wr(64'h4000_0100, E0, 1'b1);
        wr(64'h4000_0108, E1, 1'b1);
        @(posedge clk); #1 core_done = 1'b1;
        repeat (3) @(negedge clk);
        check("mismatch_no_pass", 64'(pass), 64'd0);
        check("mismatch_err_kept", 64'(err_code), 64'd1);
        core_done = 1'b0;

        // out of window read
        do_reset();
        rd(64'h5000_0000, 64'd0);
        check("oow_err", 64'(err_code), 64'd2);

        // bad size still completes
        do_reset();
        access(1'b1, 1'b0, 64'h4000_0000, 64'd0, 12'd32, 1'b1, 64'h80);
        check("size_err", 64'(err_code), 64'd3);

        // unaligned address
        do_reset();
        rd(64'h4000_0004, 64'd0);
        check("unaligned_err", 64'(err_code), 64'd2);

        // last word in window, then first word past it
        do_reset();
        core_start = 1'b0;
        preload(1'b0, 6'd63, 64'hA5A5_5A5A_1234_5678);
        core_start = 1'b1;
        rd(64'h4000_01F8, 64'hA5A5_5A5A_1234_5678);
        check("last_word_no_err", 64'(err_code), 64'd0);
        rd(64'h4000_0200, 64'd0);
        check("past_end_err", 64'(err_code), 64'd2);

        // oe and we together act as a write
        do_reset();
        frame_q.push_back(64'hDEAD_BEEF_CAFE_F00D);
        access(1'b1, 1'b1, 64'h4000_0010, 64'hDEAD_BEEF_CAFE_F00D, 12'd64, 1'b0, 64'd0);
        check("oe_we_err", 64'(err_code), 64'd4);
        rd(64'h4000_0010, 64'hDEAD_BEEF_CAFE_F00D);

        // log overflow while serialiser is busy
        do_reset();
        wr(64'h4000_0020, 64'h0123_4567_89AB_CDEF, 1'b1);
        wait_frame_start();
        wr(64'h4000_0028, 64'h1111_0000_0000_0001, 1'b1);
        wr(64'h4000_0030, 64'h2222_0000_0000_0000, 1'b1);
        wr(64'h4000_0038, 64'h8000_0000_0000_0003, 1'b1);
        wr(64'h4000_0040, 64'hF0F0_F0F0_0F0F_0F0F, 1'b1);
        check("no_overflow_at_depth", 64'(err_code), 64'd0);
        wr(64'h4000_0048, 64'h5555_5555_5555_5555, 1'b0);
        check("overflow_err", 64'(err_code), 64'd5);
        check("overflow_fail", 64'(fail), 64'd1);
        wait_frames_drained(3000);

        // reset in the middle of a frame with a word still queued
        do_reset();
        wr(64'h4000_0050, 64'hAAAA_0000_FFFF_1234, 1'b1);
        wr(64'h4000_0058, 64'h0000_0000_0000_0077, 1'b1);
        wait_frame_start();
        repeat (40) @(posedge clk);
        #1;
        check("frame_active_before_reset", 64'(la_frame), 64'd1);
        do_reset();
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (la_frame) seen = 1'b1;
        end
        check("fifo_empty_after_reset", 64'(seen), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
